esl_clk_check_seq: RTL and testbench

- Test-phase sequencer for the clock-frequency comparator in the safety clock-checker.
- Runs in the reference-clock domain and opens and closes a fixed-length measurement window for the clock-under-test (CUT) counter.
- After each window it performs a 4-phase handshake with the CUT side, samples the comparator verdicts, and confirms faults over N consecutive failures.
- Detects a dead CUT clock by handshake timeout and latches a safety fault that only an explicit clear removes.

---
 rtl/esl_clk_check_pkg.sv | 26 ++
 rtl/esl_clk_check_seq_if.sv | 35 +++
 rtl/esl_clk_check_tmo.sv | 32 +++
 rtl/esl_clk_check_seq.sv | 194 +++++++++++++++++++
 tb/tb_esl_clk_check_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/esl_clk_check_pkg.sv
// esl_clk_check_pkg -- shared types and constants for the clock-checker test-phase sequencer.
// Revision 1.0
`default_nettype none

package esl_clk_check_pkg;

   localparam int FAIL_CNT_W = 4;
   localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      RUN          = 3'd1,
      WAIT_DONE    = 3'd2,
      EVAL         = 3'd3,
      WAIT_RELEASE = 3'd4,
      GAP          = 3'd5,
      FAULT        = 3'd6
   } state_t;

   function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
      return (v == FAIL_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/esl_clk_check_seq_if.sv
// esl_clk_check_seq_if -- control, CUT handshake and status signals of the test-phase sequencer.
// Revision 1.0
`default_nettype none

interface esl_clk_check_seq_if;
   import esl_clk_check_pkg::*;

   logic                  enable;
   logic                  clear_fault;
   logic                  cut_run;
   logic                  cut_done;
   logic                  comp_too_high;
   logic                  comp_too_low;
   logic                  param_error;
   logic                  meas_valid;
   logic                  last_high;
   logic                  last_low;
   logic                  clk_dead;
   logic                  fault;
   logic [FAIL_CNT_W-1:0] fail_cnt;
   logic                  busy;

   modport master (
      output enable, clear_fault, cut_done, comp_too_high, comp_too_low, param_error,
      input  cut_run, meas_valid, last_high, last_low, clk_dead, fault, fail_cnt, busy
   );

   modport slave (
      input  enable, clear_fault, cut_done, comp_too_high, comp_too_low, param_error,
      output cut_run, meas_valid, last_high, last_low, clk_dead, fault, fail_cnt, busy
   );

endinterface

`default_nettype wire

// File: rtl/esl_clk_check_tmo.sv
// esl_clk_check_tmo -- loadable down-counter; expired_o is high while the count sits at zero.
// Revision 1.0
`default_nettype none

module esl_clk_check_tmo #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             load_i,
   input  wire logic [WIDTH-1:0] load_val_i,
   input  wire logic             en_i,
   output logic                  expired_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/esl_clk_check_seq.sv
// esl_clk_check_seq -- opens/closes CUT measurement windows, runs the 4-phase handshake, confirms faults.
// Revision 1.0
`default_nettype none

import esl_clk_check_pkg::*;

module esl_clk_check_seq #(
   parameter int WINDOW_CYCLES = 1000,
   parameter int GAP_CYCLES    = 16,
   parameter int ACK_TIMEOUT   = 64,
   parameter int FAIL_CONFIRM  = 3
) (
   input  wire logic     clk,
   input  wire logic     reset,
   esl_clk_check_seq_if.slave bus
);

   localparam int WIN_MAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
   localparam int WIN_W   = $clog2(WIN_MAX + 1);
   localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);

   // Timers load N-1 on entry so that the Nth cycle in the state is the one that sees expiry.
   localparam logic [WIN_W-1:0]      C_WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [WIN_W-1:0]      C_GAP_LOAD = WIN_W'(GAP_CYCLES - 1);
   localparam logic [ACK_W-1:0]      C_ACK_LOAD = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [FAIL_CNT_W-1:0] C_CONFIRM  = FAIL_CNT_W'(FAIL_CONFIRM);

   state_t                state_q, state_d;
   logic                  cut_run_q, cut_run_d;
   logic                  meas_valid_q, meas_valid_d;
   logic                  last_high_q, last_high_d;
   logic                  last_low_q, last_low_d;
   logic                  clk_dead_q, clk_dead_d;
   logic                  fault_q, fault_d;
   logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic                  busy_q, busy_d;

   logic                  w_state_chg;
   logic                  w_win_load, w_win_en, w_win_exp;
   logic [WIN_W-1:0]      w_win_val;
   logic                  w_ack_load, w_ack_en, w_ack_exp;
   logic [FAIL_CNT_W-1:0] w_fail_inc;

   assign w_fail_inc  = sat_inc(fail_cnt_q);
   assign w_state_chg = (state_d != state_q);
   assign w_win_load  = w_state_chg && ((state_d == RUN) || (state_d == GAP));
   assign w_win_val   = (state_d == RUN) ? C_WIN_LOAD : C_GAP_LOAD;
   assign w_win_en    = (state_q == RUN) || (state_q == GAP);
   assign w_ack_load  = w_state_chg && ((state_d == WAIT_DONE) || (state_d == WAIT_RELEASE));
   assign w_ack_en    = (state_q == WAIT_DONE) || (state_q == WAIT_RELEASE);

   esl_clk_check_tmo #(.WIDTH(WIN_W)) u_win_tmo (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_win_load),
      .load_val_i (w_win_val),
      .en_i       (w_win_en),
      .expired_o  (w_win_exp)
   );

   esl_clk_check_tmo #(.WIDTH(ACK_W)) u_ack_tmo (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_ack_load),
      .load_val_i (C_ACK_LOAD),
      .en_i       (w_ack_en),
      .expired_o  (w_ack_exp)
   );

   always_comb begin
      state_d      = state_q;
      cut_run_d    = cut_run_q;
      meas_valid_d = 1'b0;
      last_high_d  = last_high_q;
      last_low_d   = last_low_q;
      clk_dead_d   = clk_dead_q;
      fault_d      = fault_q;
      fail_cnt_d   = fail_cnt_q;

      unique case (state_q)
         IDLE: begin
            // A misconfigured comparator is a safety fault in its own right.
            if (bus.param_error) begin
               state_d = FAULT;
               fault_d = 1'b1;
            end else if (bus.enable) begin
               state_d   = RUN;
               cut_run_d = 1'b1;
            end
         end
         RUN: begin
            if (!bus.enable) begin
               state_d   = WAIT_RELEASE;
               cut_run_d = 1'b0;
            end else if (w_win_exp) begin
               state_d   = WAIT_DONE;
               cut_run_d = 1'b0;
            end
         end
         WAIT_DONE: begin
            if (bus.cut_done) begin
               state_d = EVAL;
            end else if (w_ack_exp) begin
               state_d    = FAULT;
               clk_dead_d = 1'b1;
               fault_d    = 1'b1;
            end
         end
         EVAL: begin
            meas_valid_d = 1'b1;
            last_high_d  = bus.comp_too_high;
            last_low_d   = bus.comp_too_low;
            state_d      = WAIT_RELEASE;
            if (bus.comp_too_high || bus.comp_too_low) begin
               fail_cnt_d = w_fail_inc;
               if (w_fail_inc >= C_CONFIRM) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end
            end else begin
               fail_cnt_d = '0;
            end
         end
         WAIT_RELEASE: begin
            if (!bus.cut_done) begin
               state_d = bus.enable ? GAP : IDLE;
            end else if (w_ack_exp) begin
               state_d    = FAULT;
               clk_dead_d = 1'b1;
               fault_d    = 1'b1;
            end
         end
         GAP: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else if (w_win_exp) begin
               state_d   = RUN;
               cut_run_d = 1'b1;
            end
         end
         FAULT: begin
            cut_run_d = 1'b0;
            if (bus.clear_fault && !bus.param_error) begin
               state_d    = IDLE;
               fault_d    = 1'b0;
               clk_dead_d = 1'b0;
               fail_cnt_d = '0;
            end
         end
         default: begin
            state_d   = IDLE;
            cut_run_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE) && (state_d != FAULT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cut_run_q    <= 1'b0;
         meas_valid_q <= 1'b0;
         last_high_q  <= 1'b0;
         last_low_q   <= 1'b0;
         clk_dead_q   <= 1'b0;
         fault_q      <= 1'b0;
         fail_cnt_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cut_run_q    <= cut_run_d;
         meas_valid_q <= meas_valid_d;
         last_high_q  <= last_high_d;
         last_low_q   <= last_low_d;
         clk_dead_q   <= clk_dead_d;
         fault_q      <= fault_d;
         fail_cnt_q   <= fail_cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.cut_run    = cut_run_q;
   assign bus.meas_valid = meas_valid_q;
   assign bus.last_high  = last_high_q;
   assign bus.last_low   = last_low_q;
   assign bus.clk_dead   = clk_dead_q;
   assign bus.fault      = fault_q;
   assign bus.fail_cnt   = fail_cnt_q;
   assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_esl_clk_check_seq.sv
// tb_esl_clk_check_seq -- directed and randomized phases against a fail-count/handshake model.
// Revision 1.0
`default_nettype none

module tb_esl_clk_check_seq;

   localparam int W = 10;
   localparam int G = 16;
   localparam int T = 64;
   localparam int C = 3;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   m_cnt = 0;
   bit   m_fault = 1'b0;

   esl_clk_check_seq_if bus ();

   esl_clk_check_seq #(
      .WINDOW_CYCLES (W),
      .GAP_CYCLES    (G),
      .ACK_TIMEOUT   (T),
      .FAIL_CONFIRM  (C)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered on the first sample of a window (cut_run just rose); leaves on the first
   // sample of the next window, or in FAULT when the model predicts confirmation.
   task automatic do_phase(input bit hi, input bit lo, input int d, input int r);
      int n;
      int k;
      int mv;
      n  = 1;
      mv = 0;
      while (bus.cut_run === 1'b1 && n <= W + 2) begin
         bus.cut_done = (n == 3);   // short glitch inside the window
         step();
         if (bus.meas_valid === 1'b1) mv++;
         if (bus.cut_run === 1'b1) n++;
      end
      bus.cut_done = 1'b0;
      chk("window_len", n, W);
      repeat (d) begin
         step();
         if (bus.meas_valid === 1'b1) mv++;
      end
      chk("no_early_meas", mv, 0);
      bus.comp_too_high = hi;
      bus.comp_too_low  = lo;
      bus.cut_done      = 1'b1;
      k = 0;
      while (bus.meas_valid !== 1'b1 && k < 6) begin
         step();
         k++;
      end
      // one cycle to see cut_done, one EVAL cycle
      chk("eval_latency", k, 2);
      if (hi || lo) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else          m_cnt = 0;
      m_fault = (m_cnt >= C);
      chk("fail_cnt", 32'(bus.fail_cnt), m_cnt);
      chk("last_high", 32'(bus.last_high), 32'(hi));
      chk("last_low", 32'(bus.last_low), 32'(lo));
      chk("fault", 32'(bus.fault), 32'(m_fault));
      step();
      chk("meas_pulse_width", 32'(bus.meas_valid), 0);
      repeat (r) step();
      bus.cut_done = 1'b0;
      if (m_fault) begin
         repeat (3) step();
         chk("fault_cut_run", 32'(bus.cut_run), 0);
         chk("fault_busy", 32'(bus.busy), 0);
      end else begin
         k = 0;
         while (bus.cut_run !== 1'b1 && k < G + 8) begin
            step();
            k++;
         end
         // one cycle to sample the release, then G idle gap cycles
         chk("gap_len", k, G + 1);
      end
   endtask

   // Clear with enable held: IDLE first, RUN on the following cycle.
   task automatic recover_enabled();
      bus.enable      = 1'b1;
      bus.clear_fault = 1'b1;
      step();
      bus.clear_fault = 1'b0;
      chk("clr_fault", 32'(bus.fault), 0);
      chk("clr_clk_dead", 32'(bus.clk_dead), 0);
      chk("clr_fail_cnt", 32'(bus.fail_cnt), 0);
      chk("clr_idle_cut_run", 32'(bus.cut_run), 0);
      chk("clr_idle_busy", 32'(bus.busy), 0);
      m_cnt   = 0;
      m_fault = 1'b0;
      step();
      chk("restart_run", 32'(bus.cut_run), 1);
   endtask

   initial begin
      int n;
      int mv;
      bit hi;
      bit lo;
      int d;

      reset             = 1'b1;
      bus.enable        = 1'b0;
      bus.clear_fault   = 1'b0;
      bus.cut_done      = 1'b0;
      bus.comp_too_high = 1'b0;
      bus.comp_too_low  = 1'b0;
      bus.param_error   = 1'b0;
      step();
      step();
      chk("rst_cut_run", 32'(bus.cut_run), 0);
      chk("rst_meas_valid", 32'(bus.meas_valid), 0);
      chk("rst_last", 32'({bus.last_high, bus.last_low}), 0);
      chk("rst_sticky", 32'({bus.clk_dead, bus.fault}), 0);
      chk("rst_fail_cnt", 32'(bus.fail_cnt), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      reset = 1'b0;
      step();

      // Pass path
      bus.enable = 1'b1;
      step();
      chk("run_start", 32'(bus.cut_run), 1);
      chk("run_busy", 32'(bus.busy), 1);
      do_phase(1'b0, 1'b0, 3, 2);

      // fail, fail, pass, fail; the first uses the last legal cut_done cycle
      do_phase(1'b1, 1'b0, T - 1, 1);
      do_phase(1'b0, 1'b1, 5, 0);
      do_phase(1'b0, 1'b0, 2, 3);
      do_phase(1'b1, 1'b1, 0, 4);
      do_phase(1'b0, 1'b0, 1, 1);

      // Confirmation after C consecutive fails
      do_phase(1'b1, 1'b0, 3, 1);
      do_phase(1'b1, 1'b0, 3, 1);
      do_phase(1'b1, 1'b0, 3, 1);
      chk("confirm_fault", 32'(bus.fault), 1);
      chk("confirm_cnt", 32'(bus.fail_cnt), C);
      chk("confirm_last_high", 32'(bus.last_high), 1);
      recover_enabled();

      // Randomized phases
      for (int i = 0; i < 16; i++) begin
         hi = (($urandom % 3) == 0);
         lo = (($urandom % 4) == 0);
         d  = (($urandom % 8) == 0) ? T - 1 : int'($urandom_range(0, 12));
         do_phase(hi, lo, d, int'($urandom_range(0, 5)));
         if (m_fault) recover_enabled();
      end

      // Abort at window cycle 5
      repeat (4) step();
      bus.enable = 1'b0;
      step();
      chk("abort_cut_run", 32'(bus.cut_run), 0);
      chk("abort_busy", 32'(bus.busy), 1);
      bus.cut_done = 1'b1;
      mv = 0;
      repeat (3) begin
         step();
         if (bus.meas_valid === 1'b1) mv++;
      end
      chk("abort_wait_busy", 32'(bus.busy), 1);
      bus.cut_done = 1'b0;
      step();
      if (bus.meas_valid === 1'b1) mv++;
      chk("abort_idle_busy", 32'(bus.busy), 0);
      chk("abort_no_meas", mv, 0);
      chk("abort_fail_cnt", 32'(bus.fail_cnt), m_cnt);

      // Dead CUT clock
      bus.enable = 1'b1;
      step();
      n = 0;
      while (bus.cut_run === 1'b1 && n < W + 4) begin
         step();
         n++;
      end
      repeat (T - 1) step();
      chk("dead_not_yet", 32'({bus.clk_dead, bus.fault}), 0);
      step();
      chk("dead_clk_dead", 32'(bus.clk_dead), 1);
      chk("dead_fault", 32'(bus.fault), 1);
      chk("dead_busy", 32'(bus.busy), 0);
      bus.enable      = 1'b0;
      bus.clear_fault = 1'b1;
      step();
      bus.clear_fault = 1'b0;
      chk("dead_clear", 32'({bus.clk_dead, bus.fault, bus.busy}), 0);
      chk("dead_clear_cnt", 32'(bus.fail_cnt), 0);

      // Comparator misconfiguration
      bus.param_error = 1'b1;
      bus.enable      = 1'b1;
      step();
      chk("perr_fault", 32'(bus.fault), 1);
      chk("perr_busy", 32'(bus.busy), 0);
      repeat (3) step();
      chk("perr_no_run", 32'(bus.cut_run), 0);
      bus.clear_fault = 1'b1;
      step();
      bus.clear_fault = 1'b0;
      chk("perr_clear_ignored", 32'(bus.fault), 1);
      bus.enable      = 1'b0;
      bus.param_error = 1'b0;
      bus.clear_fault = 1'b1;
      step();
      bus.clear_fault = 1'b0;
      chk("perr_cleared", 32'(bus.fault), 0);

      // Asynchronous reset in the middle of a window
      bus.enable = 1'b1;
      step();
      step();
      chk("pre_reset_run", 32'(bus.cut_run), 1);
      reset = 1'b1;
      #1;
      chk("async_reset_cut_run", 32'(bus.cut_run), 0);
      chk("async_reset_busy", 32'(bus.busy), 0);
      bus.enable = 1'b0;
      step();
      reset = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
